// File: rtl/serial_unit_sched_pkg.sv
// Shared definitions for the bit-serial datapath scheduler: FSM encoding and default sizing.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package serial_unit_sched_pkg;

    // Operation lifecycle of the shared serial datapath. All four codes are
    // used; the FSM still sends any unexpected value back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Default sizing: four requesters, 16-bit serial operand.
    localparam int DEF_NREQ      = 4;
    localparam int DEF_OP_CYCLES = 16;
    localparam int DEF_CW        = 5;
    localparam int DEF_SW        = 2;

    // Increment an index modulo n. Used for the round-robin pointer, where
    // NREQ need not be a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/serial_unit_sched_rr_pick.sv
// Round-robin picker: first set request bit scanning upward from ptr, wrapping at NREQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; win_vld is low when no request is set.
//
// Ports:
//   req      in  NREQ  request vector
//   ptr      in  SW    highest-priority index for this pick
//   win_oh   out NREQ  one-hot winner (all-zero when no request)
//   win_idx  out SW    binary index of the winner (0 when no request)
//   win_vld  out 1     a winner was found
module serial_unit_sched_rr_pick #(
    parameter int NREQ = 4,
    parameter int SW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [SW-1:0]   win_idx,
    output logic            win_vld
);

    always_comb begin
        int idx;
        idx     = 0;
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        // Walk NREQ positions starting at ptr; the first hit wins. The modulo
        // also folds any out-of-range ptr value back into the requester set.
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!win_vld && req[idx]) begin
                win_vld     = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/serial_unit_sched.sv
// Round-robin scheduler sharing one bit-serial datapath among NREQ requesters.
// Latency: req seen in IDLE at t -> start t+1, str t+1+OP_CYCLES, done t+2+OP_CYCLES; OP_CYCLES+2 per op.
// Backpressure: requesters hold req until done; req is only sampled in IDLE and DONE.
//
// Ports:
//   clk    in  1     clock, all state on rising edge
//   rst_n  in  1     asynchronous active-low reset
//   req    in  NREQ  per-requester request, held until its done pulse
//   grant  out NREQ  one-hot owner of the datapath, zero when idle
//   sel    out SW    binary owner index (datapath operand mux select), zero when idle
//   start  out 1     one-cycle load pulse to the datapath
//   str    out 1     one-cycle store strobe on the last shift cycle
//   done   out NREQ  one-cycle completion pulse to the owner
//   busy   out 1     high in LOAD, RUN and DONE
module serial_unit_sched
    import serial_unit_sched_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int OP_CYCLES = DEF_OP_CYCLES,
    parameter int CW        = DEF_CW,
    parameter int SW        = DEF_SW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [SW-1:0]   sel,
    output logic            start,
    output logic            str,
    output logic [NREQ-1:0] done,
    output logic            busy
);

    localparam logic [CW-1:0] LAST_CNT = CW'(OP_CYCLES - 1);

    state_e          state_q,    state_d;
    logic [CW-1:0]   count_q,    count_d;
    logic [SW-1:0]   owner_q,    owner_d;
    logic [NREQ-1:0] owner_oh_q, owner_oh_d;
    logic [SW-1:0]   ptr_q,      ptr_d;

    logic [SW-1:0]   owner_next;
    logic [SW-1:0]   pick_ptr;
    logic [NREQ-1:0] pick_oh;
    logic [SW-1:0]   pick_idx;
    logic            pick_vld;

    // Index just after the current owner; becomes the new pointer in DONE so
    // the requester that was just served drops to lowest priority.
    assign owner_next = SW'(wrap_inc(int'(owner_q), NREQ));

    // In DONE the pick must already see the updated pointer, otherwise the
    // owner could win back-to-back while others wait. Kept outside the FSM
    // process so the picker does not form a false loop through it.
    assign pick_ptr = (state_q == ST_DONE) ? owner_next : ptr_q;

    serial_unit_sched_rr_pick #(
        .NREQ (NREQ),
        .SW   (SW)
    ) u_rr_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_vld (pick_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            owner_q    <= '0;
            owner_oh_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            ptr_q      <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        ptr_d      = ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_d    = pick_idx;
                    owner_oh_d = pick_oh;
                    state_d    = ST_LOAD;
                end
            end

            ST_LOAD: begin
                count_d = '0;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                // Count saturates at the last shift cycle; leaving RUN is the
                // only way out, so it never wraps.
                if (count_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            ST_DONE: begin
                ptr_d = owner_next;
                if (pick_vld) begin
                    // Hand straight over to the next owner with no idle gap.
                    owner_d    = pick_idx;
                    owner_oh_d = pick_oh;
                    state_d    = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only, so they are glitch-free and
    // drop to zero the moment reset is applied.
    assign busy  = (state_q != ST_IDLE);
    assign grant = busy ? owner_oh_q : '0;
    assign sel   = busy ? owner_q : '0;
    assign start = (state_q == ST_LOAD);
    assign str   = (state_q == ST_RUN) && (count_q == LAST_CNT);
    assign done  = (state_q == ST_DONE) ? owner_oh_q : '0;

endmodule

// File: tb/tb_serial_unit_sched.sv
// Directed bench for serial_unit_sched: table of single operations plus multi-cycle corner sequences.
// Latency: n/a.
// Backpressure: requesters drop req on seeing their done pulse.
module tb_serial_unit_sched;

    localparam int NREQ      = 4;
    localparam int OP_CYCLES = 16;
    localparam int CW        = 5;
    localparam int SW        = 2;
    localparam int OP_LEN    = OP_CYCLES + 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [SW-1:0]   sel;
    logic            start;
    logic            str;
    logic [NREQ-1:0] done;
    logic            busy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    serial_unit_sched #(
        .NREQ      (NREQ),
        .OP_CYCLES (OP_CYCLES),
        .CW        (CW),
        .SW        (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant),
        .sel   (sel),
        .start (start),
        .str   (str),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {grant, sel, start, str, done, busy}.
    logic [12:0] obs;
    assign obs = {grant, sel, start, str, done, busy};

    typedef struct {
        logic [NREQ-1:0] req;
        int              owner;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {grant,sel,start,str,done,busy}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs c cycles after req is presented in IDLE (c=1 is LOAD).
    function automatic logic [12:0] exp_vec(input int owner, input int c);
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] d;
        logic [SW-1:0]   s;
        logic            b;
        oh = 4'b0001 << owner;
        b  = (c >= 1) && (c <= OP_LEN);
        g  = b ? oh : 4'b0000;
        s  = b ? SW'(owner) : 2'd0;
        d  = (c == OP_LEN) ? oh : 4'b0000;
        return {g, s, (c == 1), (c == OP_CYCLES + 1), d, b};
    endfunction

    // Invariants on every cycle: grant one-hot-or-zero, start/str/done exclusive.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if ((grant & 4'(grant - 4'd1)) != 4'b0000 ||
                $countones({start, str, |done}) > 1) begin
                fails++;
                $display("FAIL invariant @%0t: grant=%b start=%b str=%b done=%b", $time, grant, start, str, done);
            end
        end
    end

    // Called at a negedge; leaves the bench at a negedge with rst_n released.
    task automatic do_reset();
        @(negedge clk);
        req   = '0;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", obs, 13'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present r while IDLE and check every cycle of the operation. The
    // requester drops req right after the check at cycle drop_c.
    task automatic run_op(input logic [NREQ-1:0] r, input int owner, input int drop_c, input string tag);
        req = r;
        for (int c = 1; c <= OP_LEN + 1; c++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, c), obs, exp_vec(owner, c));
            if (c == drop_c) req = '0;
        end
        req = '0;
    endtask

    // Watch start pulses with req driven: checks owner order, 18-cycle spacing
    // and that each handover start directly follows a done.
    task automatic collect(input logic [NREQ-1:0] r0, input logic [NREQ-1:0] r1, input int raise_cyc,
                           input logic [9:0] exp_seq, input int nexp, input string tag);
        int n;
        int cyc;
        int last_start;
        int last_done;
        n          = 0;
        cyc        = 0;
        last_start = -1;
        last_done  = -100;
        req        = r0;
        while (n < nexp && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == raise_cyc) req = r1;
            if (start) begin
                check_int($sformatf("%s_owner%0d", tag, n), int'(sel), int'(exp_seq[2*n +: 2]));
                if (n > 0) begin
                    check_int($sformatf("%s_gap%0d", tag, n), cyc - last_start, OP_LEN);
                    check_int($sformatf("%s_done_before%0d", tag, n), last_done, cyc - 1);
                end
                last_start = cyc;
                n++;
            end
            if (done != '0) last_done = cyc;
        end
        check_int($sformatf("%s_starts_seen", tag), n, nexp);
        req = '0;
    endtask

    initial begin
        // Pointer evolution from reset (ptr=0) worked by hand per row.
        vecs[0] = '{4'b0100, 2};  // ptr 0 -> owner 2, ptr 3
        vecs[1] = '{4'b0101, 0};  // ptr 3: 3 idle, wrap to 0; ptr 1
        vecs[2] = '{4'b1100, 2};  // ptr 1: 2 first; ptr 3
        vecs[3] = '{4'b1010, 3};  // ptr 3: 3 first; ptr 0
        vecs[4] = '{4'b0010, 1};  // ptr 0: 1; ptr 2
        vecs[5] = '{4'b1001, 3};  // ptr 2: 3 before 0; ptr 0
        vecs[6] = '{4'b0011, 0};  // ptr 0: 0; ptr 1

        rst_n = 1'b0;
        req   = '0;
        #1;
        check("reset_at_time0", obs, 13'd0);
        do_reset();
        chk_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].req, vecs[i].owner, OP_LEN, $sformatf("row%0d", i));
        end

        // All four requesting: strict rotation with back-to-back handover.
        do_reset();
        collect(4'b1111, 4'b1111, 0, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, 5, "all4");

        // req0 held forever, req1 joins during op0: must alternate.
        do_reset();
        collect(4'b0001, 4'b0011, 3, {2'd0, 2'd1, 2'd0, 2'd1, 2'd0}, 4, "alt");

        // Reset mid-RUN. Move the pointer to 3 first so a stale pointer would
        // pick requester 3 instead of 0 after release.
        do_reset();
        run_op(4'b0100, 2, OP_LEN, "pre_abort");
        req = 4'b0001;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("abort_c%0d", c), obs, exp_vec(0, c));
        end
        rst_n = 1'b0;  // RUN with count 7
        #1;
        check("abort_outputs_now", obs, 13'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("abort_held_c%0d", c), obs, 13'd0);
        end
        rst_n = 1'b1;
        run_op(4'b1001, 0, OP_LEN, "post_abort");

        // Owner drops req at RUN count 3 (cycle 5): op still completes.
        do_reset();
        run_op(4'b0100, 2, 5, "drop");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("drop_idle%0d", c), obs, 13'd0);
        end

        // No requests: stays idle.
        do_reset();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check($sformatf("idle%0d", c), obs, 13'd0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
